// File: rtl/tt_host_driver.sv
// tt_host_driver: byte-stream command/response host that drives a Tiny Tapeout project's pins, clock and reset
module tt_host_driver #(
  parameter int DIV_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] ui_in,
  input  logic [7:0] uo_out,
  output logic [7:0] uio_host_out,
  output logic [7:0] uio_host_oe,
  input  logic [7:0] uio_in,
  output logic       proj_clk,
  output logic       proj_rst_n
);
  typedef enum logic [2:0] {IDLE, ARG, EXEC, STEP_HI, STEP_LO, RSP} state_t;
  state_t state_q;
  logic [7:0] op_q, arg_q, rsp2_q, uo_s1_q, uo_s2_q, uio_s1_q, uio_s2_q;
  logic hi_q, more_q;
  logic [DIV_WIDTH-1:0] div_q, cnt_q, h, c;
  logic [8:0] rem_q, rem;
  logic acc, stepping, tick, free_tick, fall, done;
  always_comb begin
    cmd_ready = !rst && (state_q == IDLE || state_q == ARG);
    acc = cmd_valid && cmd_ready;
    stepping = state_q == STEP_HI || state_q == STEP_LO || (state_q == EXEC && op_q == 8'h06);
    h = div_q == '0 ? DIV_WIDTH'(1) : div_q;
    c = state_q == EXEC ? '0 : cnt_q;
    tick = c == h - DIV_WIDTH'(1);
    free_tick = cnt_q == div_q - DIV_WIDTH'(1);
    rem = state_q == EXEC ? (arg_q == 8'd0 ? 9'd256 : {1'b0, arg_q}) + {8'd0, proj_clk} : rem_q;
    fall = tick && proj_clk;
    done = fall && rem == 9'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      arg_q <= '0;
      rsp2_q <= '0;
      uo_s1_q <= '0;
      uo_s2_q <= '0;
      uio_s1_q <= '0;
      uio_s2_q <= '0;
      hi_q <= 1'b0;
      more_q <= 1'b0;
      div_q <= '0;
      cnt_q <= '0;
      rem_q <= '0;
      rsp_data <= '0;
      rsp_valid <= 1'b0;
      ui_in <= '0;
      uio_host_out <= '0;
      uio_host_oe <= '0;
      proj_clk <= 1'b0;
      proj_rst_n <= 1'b0;
    end else begin
      {uo_s2_q, uo_s1_q} <= {uo_s1_q, uo_out};
      {uio_s2_q, uio_s1_q} <= {uio_s1_q, uio_in};
      if (stepping) begin
        cnt_q <= tick ? '0 : c + DIV_WIDTH'(1);
        proj_clk <= proj_clk ^ tick;
        rem_q <= rem - {8'd0, fall};
        state_q <= done ? RSP : ((proj_clk ^ tick) ? STEP_HI : STEP_LO);
        if (done) begin
          rsp_data <= 8'hAC;
          rsp_valid <= 1'b1;
          more_q <= 1'b0;
        end
      end else if (div_q != '0) begin
        cnt_q <= free_tick ? '0 : cnt_q + DIV_WIDTH'(1);
        proj_clk <= proj_clk ^ free_tick;
      end
      case (state_q)
        IDLE: if (acc) begin
          op_q <= cmd_data;
          hi_q <= 1'b0;
          state_q <= (cmd_data >= 8'h01 && cmd_data <= 8'h06) ? ARG : EXEC;
        end
        ARG: if (acc) begin
          arg_q <= cmd_data;
          hi_q <= 1'b1;
          state_q <= op_q == 8'h06 ? EXEC : ((op_q == 8'h05 && !hi_q) ? ARG : IDLE);
          if (op_q == 8'h01) ui_in <= cmd_data;
          if (op_q == 8'h02) uio_host_out <= cmd_data;
          if (op_q == 8'h03) uio_host_oe <= cmd_data;
          if (op_q == 8'h04) proj_rst_n <= cmd_data[0];
          if (op_q == 8'h05 && hi_q) begin
            div_q <= DIV_WIDTH'({cmd_data, arg_q});
            cnt_q <= '0;
          end
        end
        EXEC: if (op_q != 8'h06) begin
          rsp_valid <= 1'b1;
          rsp_data <= op_q == 8'h07 ? uo_s2_q : 8'hEE;
          rsp2_q <= uio_s2_q;
          more_q <= op_q == 8'h07;
          state_q <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_data <= rsp2_q;
          rsp_valid <= more_q;
          more_q <= 1'b0;
          state_q <= more_q ? RSP : IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_host_driver.sv
// tb_tt_host_driver: directed self-checking bench for tt_host_driver
module tb_tt_host_driver;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] cmd_data = 8'h00;
  logic cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [7:0] uo_out = 8'h00, uio_in = 8'h00;
  logic cmd_ready, rsp_valid, proj_clk, proj_rst_n;
  logic [7:0] rsp_data, ui_in, uio_host_out, uio_host_oe;
  int vectors = 0, miscompares = 0;
  tt_host_driver #(.DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .ui_in(ui_in), .uo_out(uo_out),
    .uio_host_out(uio_host_out), .uio_host_oe(uio_host_oe), .uio_in(uio_in), .proj_clk(proj_clk),
    .proj_rst_n(proj_rst_n)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    cmd_data = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      miscompares++;
      $display("FAIL send_timeout byte=%h cmd_ready=%b required=1", b, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    vectors++; if ({ui_in, uio_host_out, uio_host_oe, rsp_data} !== 32'h0) begin miscompares++; $display("FAIL reset_buses got=%h exp=0", {ui_in, uio_host_out, uio_host_oe, rsp_data}); end
    vectors++; if ({proj_clk, proj_rst_n, rsp_valid} !== 3'b000) begin miscompares++; $display("FAIL reset_bits got=%b exp=000", {proj_clk, proj_rst_n, rsp_valid}); end
    rst = 1'b0;
    #1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL idle_cmd_ready got=%b exp=1", cmd_ready); end
  endtask
  task automatic test_writes();
    longint t0;
    send(8'h01);
    vectors++; if (ui_in !== 8'h00) begin miscompares++; $display("FAIL ui_before_arg got=%h exp=00", ui_in); end
    send(8'hA5);
    vectors++; if (ui_in !== 8'hA5) begin miscompares++; $display("FAIL set_ui got=%h exp=a5", ui_in); end
    t0 = $time;
    send(8'h03);
    send(8'h0F);
    vectors++; if (uio_host_oe !== 8'h0F) begin miscompares++; $display("FAIL set_uio_oe got=%h exp=0f", uio_host_oe); end
    send(8'h02);
    send(8'h3C);
    vectors++; if (uio_host_out !== 8'h3C) begin miscompares++; $display("FAIL set_uio_out got=%h exp=3c", uio_host_out); end
    vectors++; if ($time - t0 != 40) begin miscompares++; $display("FAIL back_to_back got=%0d exp=40", $time - t0); end
    vectors++; if ({ui_in, proj_rst_n, rsp_valid} !== {8'hA5, 2'b00}) begin miscompares++; $display("FAIL writes_side got=%h/%b/%b exp=a5/0/0", ui_in, proj_rst_n, rsp_valid); end
  endtask
  task automatic test_read();
    uo_out = 8'h5A;
    uio_in = 8'hC3;
    tick();
    tick();
    send(8'h07);
    vectors++; if ({cmd_ready, rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL read_exec got=%b exp=00", {cmd_ready, rsp_valid}); end
    tick();
    vectors++; if ({rsp_valid, rsp_data} !== {1'b1, 8'h5A}) begin miscompares++; $display("FAIL read_b0 got=%b/%h exp=1/5a", rsp_valid, rsp_data); end
    tick();
    vectors++; if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, 8'h5A, 1'b0}) begin miscompares++; $display("FAIL read_b0_hold got=%b/%h/%b exp=1/5a/0", rsp_valid, rsp_data, cmd_ready); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++; if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, 8'hC3, 1'b0}) begin miscompares++; $display("FAIL read_b1 got=%b/%h/%b exp=1/c3/0", rsp_valid, rsp_data, cmd_ready); end
    tick();
    vectors++; if ({rsp_valid, rsp_data} !== {1'b1, 8'hC3}) begin miscompares++; $display("FAIL read_b1_hold got=%b/%h exp=1/c3", rsp_valid, rsp_data); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++; if ({rsp_valid, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL read_done got=%b exp=01", {rsp_valid, cmd_ready}); end
  endtask
  task automatic test_step_div0();
    logic [7:0] ns [2] = '{8'd3, 8'd0};
    int exp_r [2] = '{3, 256};
    for (int t = 0; t < 2; t++) begin
      int k, rises, highs;
      logic prev;
      send(8'h06);
      send(ns[t]);
      vectors++; if ({cmd_ready, rsp_valid, proj_clk} !== 3'b000) begin miscompares++; $display("FAIL step_exec n=%0d got=%b exp=000", exp_r[t], {cmd_ready, rsp_valid, proj_clk}); end
      prev = proj_clk;
      rises = 0;
      highs = 0;
      k = 0;
      while (!rsp_valid && k < 2000) begin
        tick();
        k++;
        if (proj_clk && !prev) rises++;
        if (proj_clk) highs++;
        prev = proj_clk;
      end
      vectors++; if (k != 2 * exp_r[t]) begin miscompares++; $display("FAIL step_latency n=%0d got=%0d exp=%0d", exp_r[t], k, 2 * exp_r[t]); end
      vectors++; if (rises != exp_r[t] || highs != exp_r[t]) begin miscompares++; $display("FAIL step_edges n=%0d rises=%0d highs=%0d exp=%0d", exp_r[t], rises, highs, exp_r[t]); end
      vectors++; if ({rsp_valid, rsp_data, proj_clk} !== {1'b1, 8'hAC, 1'b0}) begin miscompares++; $display("FAIL step_ack n=%0d got=%b/%h/%b exp=1/ac/0", exp_r[t], rsp_valid, rsp_data, proj_clk); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask
  task automatic test_div_step();
    int k, rises, first_low;
    logic prev;
    send(8'h05);
    send(8'h04);
    send(8'h00);
    for (int i = 1; i <= 12; i++) begin
      tick();
      vectors++; if (proj_clk !== 1'((i / 4) % 2)) begin miscompares++; $display("FAIL free_run i=%0d got=%b exp=%0d", i, proj_clk, (i / 4) % 2); end
    end
    send(8'h06);
    send(8'h02);
    vectors++; if (proj_clk !== 1'b1) begin miscompares++; $display("FAIL step_hi_start got=%b exp=1", proj_clk); end
    prev = proj_clk;
    rises = 0;
    first_low = 0;
    k = 0;
    while (!rsp_valid && k < 200) begin
      tick();
      k++;
      if (!proj_clk && first_low == 0) first_low = k;
      if (proj_clk && !prev) rises++;
      prev = proj_clk;
    end
    vectors++; if (k != 20 || first_low != 4 || rises != 2) begin miscompares++; $display("FAIL div_step got k=%0d low=%0d rises=%0d exp 20/4/2", k, first_low, rises); end
    vectors++; if ({rsp_valid, rsp_data, proj_clk} !== {1'b1, 8'hAC, 1'b0}) begin miscompares++; $display("FAIL div_step_ack got=%b/%h/%b exp=1/ac/0", rsp_valid, rsp_data, proj_clk); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    tick();
    vectors++; if (proj_clk !== 1'b0) begin miscompares++; $display("FAIL resume_low got=%b exp=0", proj_clk); end
    tick();
    vectors++; if (proj_clk !== 1'b1) begin miscompares++; $display("FAIL resume_rise got=%b exp=1", proj_clk); end
  endtask
  task automatic test_unknown();
    send(8'h42);
    vectors++; if ({cmd_ready, rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL unk_exec got=%b exp=00", {cmd_ready, rsp_valid}); end
    tick();
    vectors++; if ({rsp_valid, rsp_data} !== {1'b1, 8'hEE}) begin miscompares++; $display("FAIL unk_rsp got=%b/%h exp=1/ee", rsp_valid, rsp_data); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    send(8'h01);
    send(8'h77);
    vectors++; if ({ui_in, rsp_valid} !== {8'h77, 1'b0}) begin miscompares++; $display("FAIL unk_next_op got=%h/%b exp=77/0", ui_in, rsp_valid); end
  endtask
  task automatic test_rst_mid();
    int seen;
    send(8'h06);
    send(8'h05);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++; if ({ui_in, uio_host_out, uio_host_oe, proj_clk, proj_rst_n, rsp_valid, cmd_ready} !== 28'h0) begin miscompares++; $display("FAIL rst_step_outputs got=%h/%h/%h/%b%b%b%b exp=0", ui_in, uio_host_out, uio_host_oe, proj_clk, proj_rst_n, rsp_valid, cmd_ready); end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rsp_valid || proj_clk) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL rst_step_no_ack got=%0d exp=0", seen); end
    send(8'h07);
    tick();
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rst_read_pre got=%b exp=1", rsp_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid || rsp_data != 8'h00) seen++;
    end
    vectors++; if (seen != 0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_read_drop got=%0d/%b exp=0/1", seen, cmd_ready); end
    send(8'h04);
    vectors++; if (proj_rst_n !== 1'b0) begin miscompares++; $display("FAIL rst_n_before got=%b exp=0", proj_rst_n); end
    send(8'h01);
    vectors++; if (proj_rst_n !== 1'b1) begin miscompares++; $display("FAIL set_rst got=%b exp=1", proj_rst_n); end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_writes();
    test_read();
    test_step_div0();
    test_div_step();
    test_unknown();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tt_host_driver.md
# tt_host_driver

Host-side controller for a Tiny Tapeout project instantiated on the ECP5. It sits on the far side of the project's pin interface, playing the role of the TT demo-board host. It takes a byte-stream command channel (valid/ready) and uses it to drive the project's dedicated inputs, bidir pins, clock and reset. It samples the project's outputs and returns them on a byte-stream response channel.

## Interface
- DIV_WIDTH, 16: width of the project-clock half-period divider.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_data  in  8  command byte.
- cmd_valid  in  1  command byte valid.
- cmd_ready  out  1  driver accepts byte when cmd_valid && cmd_ready.
- rsp_data  out  8  response byte.
- rsp_valid  out  1  response byte valid; held until accepted.
- rsp_ready  in  1  response consumer ready.
- ui_in  out  8  drives project dedicated inputs.
- uo_out  in  8  project dedicated outputs.
- uio_host_out  out  8  host drive value for bidir pins.
- uio_host_oe  out  8  host output enable per bidir pin (1 = host drives).
- uio_in  in  8  bidir pin value as seen at the pad.
- proj_clk  out  1  project clock.
- proj_rst_n  out  1  project reset, active low.

## Operation
- Commands are an opcode byte followed by argument bytes. An opcode executes in the cycle after its last byte is accepted.
  - 0x01 SET_UI a: ui_in <= a.
  - 0x02 SET_UIO_OUT a: uio_host_out <= a.
  - 0x03 SET_UIO_OE a: uio_host_oe <= a.
  - 0x04 SET_RST a: proj_rst_n <= a[0].
  - 0x05 SET_DIV lo hi: div <= {hi,lo} truncated to DIV_WIDTH. Divider counter cleared.
  - 0x06 STEP n: issue n rising edges of proj_clk (n=0 means 256), then respond 0xAC.
  - 0x07 READ: respond uo_sync then uio_sync (2 bytes, in that order).
  - Any other opcode: respond 0xEE. No argument bytes are consumed.
- Write commands (0x01–0x05) produce no response.
- uo_out and uio_in each pass through a 2-flop synchronizer (uo_sync, uio_sync). READ latches both synced values in the execute cycle.
- FSM states:
  - IDLE: awaiting opcode.
  - ARG: collecting arguments.
  - STEP_HI, STEP_LO: executing STEP.
  - RSP: presenting response bytes.
- Free-run mode applies when div != 0 and state is not STEP_*:
  - Counter increments each clk.
  - When counter == div-1, proj_clk toggles and the counter clears.
  - Half-period is div cycles.
- div == 0: proj_clk holds its current level outside STEP.
- STEP timing:
  - Half-period h = div, or 1 if div == 0.
  - If proj_clk is high at execute, it first completes the high half (h cycles from execute). That falling edge is not counted.
  - Then n repetitions of (low h cycles, high h cycles), ending with a final low.
  - STEP completes on the nth falling edge; the ack is presented the same cycle.
  - Free-run resumes afterwards from proj_clk = 0 with counter 0.
- Reset values: ui_in=0, uio_host_out=0, uio_host_oe=0, proj_clk=0, proj_rst_n=0 (project held in reset), div=0, counter=0, rsp_valid=0, rsp_data=0, cmd_ready=0 during reset, synchronizers=0, state IDLE.
- rst mid-command or mid-STEP: partial command is discarded, the pending response is dropped, all outputs return to reset values next cycle.

## Timing
- cmd_ready = 1 in IDLE and ARG only. It is 0 in the execute cycle, STEP_*, and RSP.
- rsp_valid asserts the cycle after execute (READ, unknown opcode) or on STEP completion.
- rsp_data/rsp_valid are stable until rsp_ready. The second READ byte is presented the cycle after the first is accepted.
- Return to IDLE the cycle after the last response byte is accepted.
- Write commands: output updates visible 1 cycle after last byte accepted. Back-to-back commands are accepted every cycle.
- Input-to-READ latency: a pin change is reflected in READ when it occurs ≥2 cycles before the execute cycle.
- STEP n with h: n*2h cycles from execute to ack when proj_clk starts low; plus h if it starts high.

## Test plan
- Reset then SET_UI 0xA5, SET_UIO_OE 0x0F, SET_UIO_OUT 0x3C -> ui_in=0xA5, uio_host_oe=0x0F, uio_host_out=0x3C. Each updates 1 cycle after its arg. proj_rst_n stays 0.
- uo_out=0x5A, uio_in=0xC3 held; READ with rsp_ready toggling 1/0 -> bytes 0x5A then 0xC3, each held while rsp_ready=0. cmd_ready=0 until both are accepted.
- div=0; STEP 3 -> exactly 3 rising edges, each high/low phase 1 cycle, proj_clk ends 0, ack 0xAC 6 cycles after execute. STEP 0 -> 256 edges.
- SET_DIV 0x04 0x00 -> proj_clk toggles every 4 cycles. STEP 2 issued while proj_clk high -> high half completed, then 2 edges of 4/4, ack, free-run resumes from low.
- Opcode 0x42 -> rsp 0xEE; the next byte 0x01 is parsed as an opcode.
- rst asserted mid-STEP and mid-READ response -> no ack/byte delivered, all outputs at reset values, SET_RST 0x01 afterwards -> proj_rst_n=1.
